// File: rtl/tiamc1_analog_in.sv
// tiamc1_analog_in
//   Multi-channel analog input conditioner for the tiamc1 core.
//   It turns MiSTer joystick-analog, paddle and spinner streams into
//   absolute position registers. The block runs in the clk_sys domain,
//   between the hps_io outputs and the input-port decode.
//
// Ports
//   clk_sys    : system clock
//   reset_n    : asynchronous active-low reset
//   cfg_mode   : 00 joystick, 01 paddle, 10 spinner, 11 joystick
//   cfg_invert : reverse direction on all channels
//   joy_x      : signed X per channel, 8 bits each (ch0 in LSBs)
//   paddle     : unsigned paddle position per channel, 8 bits each
//   spinner    : per channel {toggle, signed delta[7:0]}, 9 bits each
//   pos        : conditioned position per channel, POS_W bits each
//   upd        : one-cycle pulse after any position changed
module tiamc1_analog_in #(
  parameter int          CHANNELS  = 2,
  parameter int          POS_W     = 8,
  parameter logic [15:0] JOY_DIV   = 16'd50000,
  parameter int          JOY_SHIFT = 4,
  parameter int          DEADZONE  = 8,
  parameter bit          SPIN_WRAP = 1'b1
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [1:0]                cfg_mode,
  input  logic                      cfg_invert,
  input  logic [CHANNELS*8-1:0]     joy_x,
  input  logic [CHANNELS*8-1:0]     paddle,
  input  logic [CHANNELS*9-1:0]     spinner,
  output logic [CHANNELS*POS_W-1:0] pos,
  output logic                      upd
);

  // The sum must hold a full +/-128 step at every POS_W. This needs at
  // least 10 bits, or POS_W+2 bits when that is wider.
  localparam int SUM_W = (POS_W + 2 > 10) ? POS_W + 2 : 10;

  localparam logic [POS_W-1:0]        CENTER  = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] POS_MAX = {{(SUM_W-POS_W){1'b0}}, {POS_W{1'b1}}};

  localparam logic [1:0] MODE_PAD  = 2'b01;
  localparam logic [1:0] MODE_SPIN = 2'b10;

  // Clamp a widened signed sum into [0, 2^POS_W-1].
  function automatic logic [POS_W-1:0] sat_pos(input logic signed [SUM_W-1:0] s);
    if (s[SUM_W-1])   return '0;
    if (s > POS_MAX)  return '1;
    return s[POS_W-1:0];
  endfunction

  // Widen an unsigned position to a non-negative signed sum operand.
  function automatic logic signed [SUM_W-1:0] pos_ext(input logic [POS_W-1:0] p);
    return {{(SUM_W-POS_W){1'b0}}, p};
  endfunction

  // Sign-extend an 8-bit value to 9 bits and negate it on request.
  // Nine bits let -128 become +128 without overflow.
  function automatic logic signed [8:0] signed9(input logic [7:0] x, input logic inv);
    logic signed [8:0] v;
    v = {x[7], x};
    if (inv) v = -v;
    return v;
  endfunction

  // Joystick step: zero inside the dead zone, else an arithmetic right shift.
  function automatic logic signed [SUM_W-1:0] joy_step(input logic [7:0] x, input logic inv);
    logic signed [8:0] v;
    logic signed [8:0] sh;
    logic        [8:0] mag;
    v   = signed9(x, inv);
    mag = v[8] ? 9'(-v) : 9'(v);
    if (mag <= 9'(DEADZONE)) return '0;
    sh = v >>> JOY_SHIFT;
    return {{(SUM_W-9){sh[8]}}, sh};
  endfunction

  // Paddle value, optionally inverted (255-p is the same as ~p). The
  // result is left-aligned into POS_W bits: the value is padded on the
  // right, then its top POS_W bits are kept.
  function automatic logic [POS_W-1:0] pad_scale(input logic [7:0] p, input logic inv);
    logic [7:0]       pp;
    logic [POS_W+7:0] wide;
    pp   = inv ? ~p : p;
    wide = {pp, {POS_W{1'b0}}};
    return wide[POS_W+7:8];
  endfunction

  // Spinner step: wrap modulo 2^POS_W or saturate.
  function automatic logic [POS_W-1:0] spin_next(input logic [POS_W-1:0] p,
                                                 input logic [7:0]       dlt,
                                                 input logic             inv);
    logic signed [8:0]       d9;
    logic signed [SUM_W-1:0] sum;
    d9  = signed9(dlt, inv);
    sum = pos_ext(p) + {{(SUM_W-9){d9[8]}}, d9};
    if (SPIN_WRAP) return sum[POS_W-1:0];
    return sat_pos(sum);
  endfunction

  logic [15:0]         cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [CHANNELS-1:0] shadow_q, shadow_d;
  logic [POS_W-1:0]    pos_q [CHANNELS];
  logic [POS_W-1:0]    pos_d [CHANNELS];
  logic                upd_q, upd_d;
  logic                tick;
  logic                mode_chg;

  always_comb begin
    tick     = (cnt_q == JOY_DIV - 16'd1);
    cnt_d    = tick ? 16'd0 : cnt_q + 16'd1;
    mode_chg = (cfg_mode != mode_q);
    mode_d   = cfg_mode;
    shadow_d = shadow_q;
    upd_d    = mode_chg;
    for (int c = 0; c < CHANNELS; c++) begin
      pos_d[c] = pos_q[c];
      if (mode_chg) begin
        // Recentre, and resync the shadow so the next toggle is the first step.
        pos_d[c]    = CENTER;
        shadow_d[c] = spinner[c*9+8];
      end else begin
        case (mode_q)
          MODE_PAD: pos_d[c] = pad_scale(paddle[c*8 +: 8], cfg_invert);
          MODE_SPIN: begin
            if (spinner[c*9+8] != shadow_q[c]) begin
              shadow_d[c] = spinner[c*9+8];
              pos_d[c]    = spin_next(pos_q[c], spinner[c*9 +: 8], cfg_invert);
            end
          end
          default: begin
            if (tick)
              pos_d[c] = sat_pos(pos_ext(pos_q[c]) + joy_step(joy_x[c*8 +: 8], cfg_invert));
          end
        endcase
      end
      if (pos_d[c] != pos_q[c]) upd_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      mode_q   <= 2'b00;
      shadow_q <= '0;
      upd_q    <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) pos_q[c] <= CENTER;
    end else begin
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      shadow_q <= shadow_d;
      upd_q    <= upd_d;
      for (int c = 0; c < CHANNELS; c++) pos_q[c] <= pos_d[c];
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pos
    assign pos[g*POS_W +: POS_W] = pos_q[g];
  end

  assign upd = upd_q;

endmodule

// File: tb/tb_tiamc1_analog_in.sv
// tb_tiamc1_analog_in
//   Drives a wrapping instance and a saturating instance of
//   tiamc1_analog_in with the same stimulus. Every cycle, both instances
//   are compared against an integer reference model. Directed steps pin
//   down known positions.
module tb_tiamc1_analog_in;

  localparam int JOYDIV = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  cfg_mode = 2'b00;
  logic        cfg_invert = 1'b0;
  logic [15:0] joy_x = '0;
  logic [15:0] paddle = '0;
  logic [17:0] spinner = '0;
  logic [15:0] pos_w, pos_s;
  logic        upd_w, upd_s;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: [0] = wrapping instance, [1] = saturating instance.
  int          m_pos [2][2];
  logic [1:0]  m_upd;
  logic        m_sh [2];
  logic [1:0]  m_mode;
  int          m_cnt;

  always #5 clk = ~clk;

  tiamc1_analog_in #(.CHANNELS(2), .POS_W(8), .JOY_DIV(16'(JOYDIV)), .JOY_SHIFT(4),
                     .DEADZONE(8), .SPIN_WRAP(1'b1)) dut_wrap (
    .clk_sys(clk), .reset_n(reset_n), .cfg_mode(cfg_mode), .cfg_invert(cfg_invert),
    .joy_x(joy_x), .paddle(paddle), .spinner(spinner), .pos(pos_w), .upd(upd_w));

  tiamc1_analog_in #(.CHANNELS(2), .POS_W(8), .JOY_DIV(16'(JOYDIV)), .JOY_SHIFT(4),
                     .DEADZONE(8), .SPIN_WRAP(1'b0)) dut_sat (
    .clk_sys(clk), .reset_n(reset_n), .cfg_mode(cfg_mode), .cfg_invert(cfg_invert),
    .joy_x(joy_x), .paddle(paddle), .spinner(spinner), .pos(pos_s), .upd(upd_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clampi(input int x);
    if (x < 0)   return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 2; c++) m_pos[d][c] = 128;
    m_sh[0] = 1'b0; m_sh[1] = 1'b0;
    m_mode = 2'b00; m_cnt = 0; m_upd = 2'b00;
  endtask

  // One clock of the reference behaviour, applied to the inputs present now.
  task automatic model_step();
    logic       chg, tk, tg;
    logic [1:0] any;
    int         np, v, p, dl;
    chg = (cfg_mode != m_mode);
    tk  = (m_cnt == JOYDIV - 1);
    any = {chg, chg};
    for (int c = 0; c < 2; c++) begin
      tg = spinner[c*9+8];
      for (int d = 0; d < 2; d++) begin
        np = m_pos[d][c];
        if (chg) np = 128;
        else if (m_mode == 2'd1) begin
          p = int'(paddle[c*8 +: 8]);
          if (cfg_invert) p = 255 - p;
          np = p;
        end else if (m_mode == 2'd2) begin
          if (tg != m_sh[c]) begin
            dl = int'($signed(spinner[c*9 +: 8]));
            if (cfg_invert) dl = -dl;
            np = (d == 0) ? ((np + dl) & 255) : clampi(np + dl);
          end
        end else if (tk) begin
          v = int'($signed(joy_x[c*8 +: 8]));
          if (cfg_invert) v = -v;
          if (v > 8 || v < -8) np = clampi(np + (v >>> 4));
        end
        if (np != m_pos[d][c]) any[d] = 1'b1;
        m_pos[d][c] = np;
      end
      if (chg || m_mode == 2'd2) m_sh[c] = tg;
    end
    m_cnt  = tk ? 0 : m_cnt + 1;
    m_mode = cfg_mode;
    m_upd  = any;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("wrap_pos0", 32'(pos_w[7:0]),  32'(m_pos[0][0]));
    chk("wrap_pos1", 32'(pos_w[15:8]), 32'(m_pos[0][1]));
    chk("sat_pos0",  32'(pos_s[7:0]),  32'(m_pos[1][0]));
    chk("sat_pos1",  32'(pos_s[15:8]), 32'(m_pos[1][1]));
    chk("wrap_upd",  32'(upd_w), 32'(m_upd[0]));
    chk("sat_upd",   32'(upd_s), 32'(m_upd[1]));
  endtask

  task automatic cycn(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic spin(input int ch, input logic [7:0] dlt, input logic toggle);
    spinner[ch*9 +: 8] = dlt;
    if (toggle) spinner[ch*9+8] = ~spinner[ch*9+8];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset.
    #2 reset_n = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    chk("rst_pos_w", 32'(pos_w), 32'h8080);
    chk("rst_pos_s", 32'(pos_s), 32'h8080);
    chk("rst_upd",   32'(upd_w), 32'd0);

    // Joystick integration: +64 moves ch0 by +4 per tick.
    joy_x = 16'h0040;
    cycn(JOYDIV);
    chk("joy_tick1", 32'(pos_w[7:0]), 32'h84);
    cycn(JOYDIV);
    chk("joy_tick2", 32'(pos_w[7:0]), 32'h88);
    chk("joy_ch1_idle", 32'(pos_w[15:8]), 32'h80);
    joy_x = 16'h0005;
    cycn(2 * JOYDIV);
    chk("joy_deadzone", 32'(pos_w[7:0]), 32'h88);
    joy_x = 16'h0080;
    cycn(40 * JOYDIV);
    chk("joy_clamp_lo", 32'(pos_w[7:0]), 32'h00);
    cfg_invert = 1'b1;
    cycn(40 * JOYDIV);
    chk("joy_inv_clamp_hi", 32'(pos_w[7:0]), 32'hFF);

    // Paddle: one-cycle latency, then inversion.
    cfg_invert = 1'b0;
    paddle = 16'h3011;
    cfg_mode = 2'b01;
    cyc();
    chk("pad_recentre", 32'(pos_w), 32'h8080);
    chk("pad_recentre_upd", 32'(upd_w), 32'd1);
    cyc();
    chk("pad_ch1", 32'(pos_w[15:8]), 32'h30);
    chk("pad_upd", 32'(upd_w), 32'd1);
    cyc();
    chk("pad_upd_drop", 32'(upd_w), 32'd0);
    cfg_invert = 1'b1;
    cyc();
    chk("pad_inv_ch1", 32'(pos_w[15:8]), 32'hCF);

    // Spinner: reach 0xFE, then step +4 across the top.
    cfg_invert = 1'b0;
    cfg_mode = 2'b10;
    cyc();
    spin(0, 8'd126, 1'b1);
    cyc();
    chk("spin_fe", 32'(pos_w[7:0]), 32'hFE);
    spin(0, 8'd4, 1'b1);
    cyc();
    chk("spin_wrap", 32'(pos_w[7:0]), 32'h02);
    chk("spin_sat",  32'(pos_s[7:0]), 32'hFF);
    spin(0, 8'hFD, 1'b0);
    cycn(2);
    chk("spin_no_toggle", 32'(pos_w[7:0]), 32'h02);
    spin(1, 8'd0, 1'b1);
    cyc();
    chk("spin_zero_delta", 32'(pos_w[15:8]), 32'h80);

    // A mode switch in the same cycle as a tick and a spinner toggle.
    for (int i = 0; i < 2 * JOYDIV && m_cnt != JOYDIV - 1; i++) cyc();
    chk("tick_align", 32'(m_cnt), 32'(JOYDIV - 1));
    spin(0, 8'd40, 1'b1);
    spin(1, 8'd40, 1'b1);
    joy_x = 16'h8040;
    cfg_mode = 2'b00;
    cyc();
    chk("switch_pos_w", 32'(pos_w), 32'h8080);
    chk("switch_pos_s", 32'(pos_s), 32'h8080);
    chk("switch_upd", 32'(upd_w), 32'd1);
    joy_x = 16'h0000;
    cyc();
    chk("switch_upd_drop", 32'(upd_w), 32'd0);

    // Asynchronous reset in the middle of a cycle.
    paddle = 16'h3333;
    cfg_mode = 2'b01;
    cycn(2);
    chk("pre_rst_pos", 32'(pos_w), 32'h3333);
    #3 reset_n = 1'b0;
    #1;
    chk("async_rst_pos", 32'(pos_w), 32'h8080);
    chk("async_rst_upd", 32'(upd_w), 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;

    // Random segments across all modes.
    for (int seg = 0; seg < 14; seg++) begin
      cfg_mode   = 2'($urandom_range(0, 3));
      cfg_invert = 1'($urandom_range(0, 1));
      for (int i = 0; i < 140; i++) begin
        joy_x  = 16'($urandom);
        paddle = 16'($urandom);
        for (int c = 0; c < 2; c++) spin(c, 8'($urandom), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 40) == 0) cfg_invert = ~cfg_invert;
        cyc();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
